// File: rtl/atm_pkg.sv
// rtl/atm_pkg.sv - ATM state, status and menu codes shared with the datapath
package atm_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_ACC_NUM    = 4'd1,
    ST_ACC_CHK    = 4'd2,
    ST_PIN_INPUT  = 4'd3,
    ST_PIN_CHK    = 4'd4,
    ST_MENU       = 4'd5,
    ST_SHOW_BAL   = 4'd6,
    ST_SEL_AMT_WD = 4'd7,
    ST_WD_CHK     = 4'd8,
    ST_TRANSFER   = 4'd9,
    ST_XFER_CHK   = 4'd10,
    ST_ERROR      = 4'd13,
    ST_SUCCESS    = 4'd14,
    ST_LOCKED     = 4'd15
  } atm_state_e;

  typedef enum logic [3:0] {
    STS_NONE           = 4'd0,
    STS_ACC_FOUND      = 4'd1,
    STS_ACC_NOT_FOUND  = 4'd2,
    STS_PIN_OK         = 4'd3,
    STS_PIN_BAD        = 4'd4,
    STS_TXN_OK         = 4'd5,
    STS_TXN_FAIL       = 4'd6,
    STS_BAL_READY      = 4'd7,
    STS_INPUT_COMPLETE = 4'd8
  } atm_status_e;

  typedef enum logic [1:0] {
    OPT_BALANCE  = 2'd0,
    OPT_WITHDRAW = 2'd1,
    OPT_TRANSFER = 2'd2,
    OPT_EXIT     = 2'd3
  } atm_menu_e;

  function automatic logic is_chk_state(atm_state_e s);
    return s inside {ST_ACC_CHK, ST_PIN_CHK, ST_WD_CHK, ST_XFER_CHK};
  endfunction

endpackage

// File: rtl/atm_hold_timer.sv
// rtl/atm_hold_timer.sv - loadable down-counter, done while the count sits at zero
module atm_hold_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] cnt_q, cnt_d;

  // Saturates at zero so a long stay never wraps back into a fresh count
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == '0);

endmodule

// File: rtl/atm_session_ctrl.sv
// rtl/atm_session_ctrl.sv - ATM session sequencer with settle sampling, PIN lockout, message hold
// Optional inactivity logout when ATM_TIMEOUT_EN is defined.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int unsigned MAX_PIN_TRIES = 3,
  parameter int unsigned SETTLE_CYC    = 2,
  parameter int unsigned MSG_HOLD_CYC  = 100_000_000,
  parameter int unsigned TIMEOUT_CYC   = 1_000_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       card_in,
  input  logic       btn_enter,
  input  logic       btn_back,
  input  logic [1:0] menu_option,
  input  logic [3:0] status_code,
  output logic [3:0] current_state,
  output logic       dp_eval,
  output logic       session_active,
  output logic       lockout,
  output logic [1:0] pin_tries_left,
  output logic       timeout_evt
);

  localparam logic [1:0] MAX_TRIES = 2'(MAX_PIN_TRIES);

  atm_state_e  state_q, state_d;
  logic [1:0]  tries_q, tries_d;
  logic        session_q, session_d;
  logic        dp_eval_q, dp_eval_d;
  logic        lockout_q, lockout_d;
  logic        hold_done, state_chg, timeout_hit;
  logic [31:0] hold_len;

  always_comb begin
    state_d   = state_q;
    tries_d   = tries_q;
    session_d = session_q;
    if (!card_in) begin
      state_d = ST_IDLE;
    end else if (timeout_hit) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ACC_NUM;
          tries_d = MAX_TRIES;
        end
        ST_ACC_NUM:    if (btn_back) state_d = ST_IDLE; else if (btn_enter) state_d = ST_ACC_CHK;
        ST_PIN_INPUT:  if (btn_back) state_d = ST_IDLE; else if (btn_enter) state_d = ST_PIN_CHK;
        ST_SEL_AMT_WD: if (btn_back) state_d = ST_MENU; else if (btn_enter) state_d = ST_WD_CHK;
        ST_TRANSFER:   if (btn_back) state_d = ST_MENU; else if (btn_enter) state_d = ST_XFER_CHK;
        ST_SHOW_BAL:   if (btn_back || btn_enter) state_d = ST_MENU;
        ST_MENU: begin
          if (btn_enter && !btn_back) begin
            case (atm_menu_e'(menu_option))
              OPT_BALANCE:  state_d = ST_SHOW_BAL;
              OPT_WITHDRAW: state_d = ST_SEL_AMT_WD;
              OPT_TRANSFER: state_d = ST_TRANSFER;
              default:      state_d = ST_IDLE;
            endcase
          end
        end
        ST_ACC_CHK: begin
          if (hold_done) state_d = (status_code == STS_ACC_FOUND) ? ST_PIN_INPUT : ST_ERROR;
        end
        ST_PIN_CHK: begin
          if (hold_done) begin
            if (status_code == STS_PIN_OK) begin
              state_d   = ST_MENU;
              session_d = 1'b1;
            end else if (status_code == STS_PIN_BAD) begin
              tries_d = tries_q - 2'd1;
              state_d = (tries_q <= 2'd1) ? ST_LOCKED : ST_PIN_INPUT;
            end else begin
              state_d = ST_ERROR;
            end
          end
        end
        ST_WD_CHK, ST_XFER_CHK: begin
          if (hold_done) state_d = (status_code == STS_TXN_OK) ? ST_SUCCESS : ST_ERROR;
        end
        // Back simply ends the message early, so it trivially wins over the hold expiring
        ST_ERROR, ST_SUCCESS: begin
          if (btn_back || btn_enter || hold_done) state_d = session_q ? ST_MENU : ST_ACC_NUM;
        end
        ST_LOCKED: state_d = ST_LOCKED;
        default:   state_d = ST_IDLE;
      endcase
    end
    if (state_d == ST_IDLE) session_d = 1'b0;
    dp_eval_d = is_chk_state(state_d);
    lockout_d = (state_d == ST_LOCKED);
  end

  assign state_chg = (state_d != state_q);

  always_comb begin
    hold_len = '0;
    if (is_chk_state(state_d)) begin
      hold_len = SETTLE_CYC - 32'd1;
    end else if (state_d inside {ST_ERROR, ST_SUCCESS}) begin
      hold_len = MSG_HOLD_CYC - 32'd1;
    end
  end

  atm_hold_timer #(.W(32)) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state_chg),
    .load_val (hold_len),
    .done     (hold_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      tries_q   <= MAX_TRIES;
      session_q <= 1'b0;
      dp_eval_q <= 1'b0;
      lockout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      tries_q   <= tries_d;
      session_q <= session_d;
      dp_eval_q <= dp_eval_d;
      lockout_q <= lockout_d;
    end
  end

`ifdef ATM_TIMEOUT_EN
  logic [31:0] idle_cnt_q, idle_cnt_d;
  logic        timeout_evt_q, timeout_evt_d;

  // Only states waiting on the user can time out; checks and lockout never do
  assign timeout_hit = !(state_q inside {ST_IDLE, ST_LOCKED}) && !is_chk_state(state_q)
                       && (idle_cnt_q >= TIMEOUT_CYC - 32'd1);

  always_comb begin
    idle_cnt_d = idle_cnt_q;
    if (btn_enter || btn_back || state_chg) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != 32'hFFFF_FFFF) begin
      idle_cnt_d = idle_cnt_q + 32'd1;
    end
    timeout_evt_d = timeout_hit && card_in;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idle_cnt_q    <= '0;
      timeout_evt_q <= 1'b0;
    end else begin
      idle_cnt_q    <= idle_cnt_d;
      timeout_evt_q <= timeout_evt_d;
    end
  end

  assign timeout_evt = timeout_evt_q;
`else
  logic [31:0] timeout_cyc_unused;
  assign timeout_cyc_unused = TIMEOUT_CYC;
  assign timeout_hit        = 1'b0;
  assign timeout_evt        = 1'b0;
`endif

  assign current_state  = state_q;
  assign dp_eval        = dp_eval_q;
  assign session_active = session_q;
  assign lockout        = lockout_q;
  assign pin_tries_left = tries_q;

endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb/tb_atm_session_ctrl.sv - directed bench with a cycle-level session model for atm_session_ctrl
module tb_atm_session_ctrl;

  localparam int MAX_TRIES = 3;
  localparam int SETTLE    = 2;
  localparam int HOLD      = 8;
  localparam int TIMEOUT   = 50;

  logic       clk = 1'b0;
  logic       rst_n, card_in, btn_enter, btn_back;
  logic [1:0] menu_option, pin_tries_left;
  logic [3:0] status_code, current_state;
  logic       dp_eval, session_active, lockout, timeout_evt;

  int n_vec  = 0;
  int n_miss = 0;

  atm_session_ctrl #(
    .MAX_PIN_TRIES (MAX_TRIES),
    .SETTLE_CYC    (SETTLE),
    .MSG_HOLD_CYC  (HOLD),
    .TIMEOUT_CYC   (TIMEOUT)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .card_in        (card_in),
    .btn_enter      (btn_enter),
    .btn_back       (btn_back),
    .menu_option    (menu_option),
    .status_code    (status_code),
    .current_state  (current_state),
    .dp_eval        (dp_eval),
    .session_active (session_active),
    .lockout        (lockout),
    .pin_tries_left (pin_tries_left),
    .timeout_evt    (timeout_evt)
  );

  always #5 clk = ~clk;

  // Session model: state as a plain number plus "cycles spent here" and "cycles since last activity"
  int m_st, m_age, m_idle, m_tries;
  bit m_sess, m_tevt, m_valid = 1'b0;

  always @(posedge clk) begin
    int nxt;
    if (!rst_n) begin
      m_st = 0; m_age = 0; m_idle = 0; m_tries = MAX_TRIES;
      m_sess = 0; m_tevt = 0; m_valid = 1'b1;
    end else begin
      nxt = m_st;
      m_tevt = 0;
      if (!card_in) begin
        nxt = 0;
`ifdef ATM_TIMEOUT_EN
      end else if (!(m_st inside {0, 2, 4, 8, 10, 15}) && (m_idle + 1 == TIMEOUT)) begin
        nxt = 0;
        m_tevt = 1;
`endif
      end else begin
        case (m_st)
          0: begin nxt = 1; m_tries = MAX_TRIES; end
          1: nxt = btn_back ? 0 : (btn_enter ? 2 : 1);
          3: nxt = btn_back ? 0 : (btn_enter ? 4 : 3);
          7: nxt = btn_back ? 5 : (btn_enter ? 8 : 7);
          9: nxt = btn_back ? 5 : (btn_enter ? 10 : 9);
          6: if (btn_back || btn_enter) nxt = 5;
          5: if (btn_enter && !btn_back) nxt = (menu_option == 0) ? 6 : (menu_option == 1) ? 7 :
                                               (menu_option == 2) ? 9 : 0;
          2: if (m_age == SETTLE - 1) nxt = (status_code == 1) ? 3 : 13;
          4: if (m_age == SETTLE - 1) begin
               if (status_code == 3) begin nxt = 5; m_sess = 1; end
               else if (status_code == 4) begin m_tries = m_tries - 1; nxt = (m_tries == 0) ? 15 : 3; end
               else nxt = 13;
             end
          8, 10: if (m_age == SETTLE - 1) nxt = (status_code == 5) ? 14 : 13;
          13, 14: if (btn_back || btn_enter || m_age == HOLD - 1) nxt = m_sess ? 5 : 1;
          default: ;
        endcase
      end
      if (nxt == 0) m_sess = 0;
      m_idle = (btn_enter || btn_back || nxt != m_st) ? 0 : m_idle + 1;
      m_age  = (nxt != m_st) ? 0 : m_age + 1;
      m_st   = nxt;
    end
  end

  always @(negedge clk) begin
    bit exp_dp;
    if (m_valid) begin
      exp_dp = m_st inside {2, 4, 8, 10};
      n_vec++;
      if (current_state !== 4'(m_st) || dp_eval !== exp_dp || session_active !== m_sess ||
          lockout !== (m_st == 15) || pin_tries_left !== 2'(m_tries) || timeout_evt !== m_tevt) begin
        n_miss++;
        $display("FAIL model t=%0t: got st=%0d dp=%0b sess=%0b lock=%0b tries=%0d tevt=%0b, expected st=%0d dp=%0b sess=%0b lock=%0b tries=%0d tevt=%0b",
                 $time, current_state, dp_eval, session_active, lockout, pin_tries_left, timeout_evt,
                 m_st, exp_dp, m_sess, (m_st == 15), m_tries, m_tevt);
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input bit e, input bit b);
    btn_enter = e;
    btn_back  = b;
    @(negedge clk);
    btn_enter = 1'b0;
    btn_back  = 1'b0;
  endtask

  task automatic wait_state(input int exp, input int limit, input string name);
    int n = 0;
    while (int'(current_state) != exp && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(current_state), exp);
  endtask

  task automatic count_stay(input int st, input int exp, input string name);
    int n = 0;
    while (int'(current_state) == st && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, n, exp);
  endtask

  task automatic login();
    status_code = 4'd1;
    press(1, 0);
    wait_state(3, 6, "acc_to_pin");
    status_code = 4'd3;
    press(1, 0);
    wait_state(5, 6, "pin_to_menu");
  endtask

  initial begin
    rst_n = 1'b0; card_in = 1'b0; btn_enter = 1'b0; btn_back = 1'b0;
    menu_option = 2'd0; status_code = 4'd0;
    tick(3);
    check("reset_state", current_state, 0);
    check("reset_tries", pin_tries_left, 3);
    check("reset_flags", {dp_eval, session_active, lockout, timeout_evt}, 0);
    rst_n = 1'b1;
    tick(1);

    // happy path
    card_in = 1'b1;
    tick(1);
    check("card_to_acc_num", current_state, 1);
    status_code = 4'd1;
    press(1, 0);
    check("acc_chk_state", current_state, 2);
    check("acc_chk_dp_eval", dp_eval, 1);
    wait_state(3, 6, "acc_found");
    status_code = 4'd3;
    press(1, 0);
    wait_state(5, 6, "pin_ok_menu");
    check("happy_session", session_active, 1);
    check("happy_tries", pin_tries_left, 3);

    // menu exit, then bad PIN three times
    menu_option = 2'd3;
    press(1, 0);
    check("exit_idle", current_state, 0);
    check("exit_session", session_active, 0);
    tick(1);
    status_code = 4'd1;
    press(1, 0);
    wait_state(3, 6, "bad_pin_setup");
    status_code = 4'd4;
    press(1, 0);
    wait_state(3, 6, "bad_pin_1");
    check("tries_2", pin_tries_left, 2);
    press(1, 0);
    wait_state(3, 6, "bad_pin_2");
    check("tries_1", pin_tries_left, 1);
    press(1, 0);
    wait_state(15, 6, "locked");
    check("tries_0", pin_tries_left, 0);
    check("lockout_flag", lockout, 1);
    press(1, 1);
    check("locked_ignores_buttons", current_state, 15);
    card_in = 1'b0;
    tick(1);
    check("locked_card_out", current_state, 0);

    // withdraw: fail, success, skip hold
    card_in = 1'b1;
    tick(1);
    login();
    menu_option = 2'd1;
    press(1, 0);
    check("sel_amt_wd", current_state, 7);
    status_code = 4'd6;
    press(1, 0);
    wait_state(13, 6, "wd_fail_error");
    count_stay(13, HOLD, "error_hold_len");
    check("error_to_menu", current_state, 5);
    press(1, 0);
    status_code = 4'd5;
    press(1, 0);
    wait_state(14, 6, "wd_ok_success");
    count_stay(14, HOLD, "success_hold_len");
    check("success_to_menu", current_state, 5);
    press(1, 0);
    status_code = 4'd6;
    press(1, 0);
    wait_state(13, 6, "skip_error");
    press(1, 0);
    check("enter_skips_hold", current_state, 5);

    // enter+back together in SEL_AMT_WD
    press(1, 0);
    press(1, 1);
    check("enter_back_back_wins", current_state, 5);

    // unknown status in ACC_CHK
    menu_option = 2'd3;
    press(1, 0);
    tick(1);
    status_code = 4'd9;
    press(1, 0);
    wait_state(13, 6, "acc_chk_bad_code");
    check("no_session_error", session_active, 0);
    wait_state(1, 12, "error_to_acc_num");

    // card pulled during WD_CHK
    login();
    menu_option = 2'd1;
    press(1, 0);
    status_code = 4'd5;
    press(1, 0);
    check("in_wd_chk", current_state, 8);
    card_in = 1'b0;
    tick(1);
    check("pull_idle", current_state, 0);
    check("pull_session", session_active, 0);

    // reset mid-hold restores tries
    card_in = 1'b1;
    tick(1);
    status_code = 4'd1;
    press(1, 0);
    wait_state(3, 6, "rst_setup");
    status_code = 4'd4;
    press(1, 0);
    wait_state(3, 6, "rst_bad_pin");
    status_code = 4'd9;
    press(1, 0);
    wait_state(13, 6, "rst_error");
    tick(2);
    rst_n = 1'b0;
    tick(1);
    check("midhold_rst_state", current_state, 0);
    check("midhold_rst_tries", pin_tries_left, 3);
    check("midhold_rst_flags", {dp_eval, session_active, lockout, timeout_evt}, 0);
    rst_n = 1'b1;
    tick(1);

`ifdef ATM_TIMEOUT_EN
    login();
    count_stay(5, TIMEOUT, "menu_timeout_len");
    check("timeout_idle", current_state, 0);
    check("timeout_pulse", timeout_evt, 1);
    tick(1);
    check("timeout_pulse_end", timeout_evt, 0);
    status_code = 4'd1;
    press(1, 0);
    wait_state(3, 6, "to_lock_setup");
    status_code = 4'd4;
    repeat (3) begin
      press(1, 0);
      tick(SETTLE + 1);
    end
    wait_state(15, 6, "to_locked");
    tick(TIMEOUT + 10);
    check("locked_no_timeout", current_state, 15);
`endif

    card_in = 1'b0;
    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
